// File: rtl/sgdma_pkg.sv
// sgdma_pkg: sequencer states, descriptor layout and flag positions shared by the DMA blocks
package sgdma_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE,
        S_ERROR
    } state_t;

    localparam int W_NEXT  = 0;
    localparam int W_ADDR  = 1;
    localparam int W_LEN   = 2;
    localparam int W_FLAGS = 3;

    localparam int F_IRQ  = 0;
    localparam int F_LAST = 1;

    typedef struct packed {
        logic [31:0] next;
        logic [31:0] addr;
        logic [31:0] len;
        logic [31:0] flags;
    } desc_t;

    function automatic logic is_busy(input state_t s);
        return !(s == S_IDLE || s == S_ERROR);
    endfunction

endpackage

// File: rtl/sgdma_desc_sequencer.sv
// sgdma_desc_sequencer: walks a linked descriptor chain and issues one data-mover command per descriptor
module sgdma_desc_sequencer
    import sgdma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 23,
    parameter int CNT_W  = 16
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] head_ptr,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [31:0]       rd_data,
    input  logic              rd_err,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    input  logic              xfer_done,
    output logic              busy,
    output logic              irq_desc,
    output logic              irq_chain,
    output logic              err,
    output logic [CNT_W-1:0]  desc_count
);

    state_t            state, state_n;
    logic [ADDR_W-1:0] cur_ptr;
    logic [1:0]        idx;
    logic              gap;
    logic              stop_pending;
    logic [31:0]       words [4];
    desc_t             desc;
    logic              accept, bad_head, ack, len_zero, fetch_done, done_evt, irq_evt, chain_end, next_bad;
    logic              unused_bits;

    assign desc        = {words[W_NEXT], words[W_ADDR], words[W_LEN], words[W_FLAGS]};
    assign unused_bits = ^{desc.len[31:LEN_W], desc.flags[31:2]};
    assign cmd_addr    = desc.addr[ADDR_W-1:0];
    assign cmd_len     = desc.len[LEN_W-1:0];
    assign rd_addr     = cur_ptr + ADDR_W'({idx, 2'b00});

    // next-state decode and handshake outputs; a zero-length descriptor completes straight out of FETCH
    always_comb begin
        state_n    = state;
        busy       = is_busy(state);
        rd_req     = state == S_FETCH && !gap;
        cmd_valid  = state == S_ISSUE;
        ack        = rd_req && rd_ack;
        accept     = !busy && start;
        bad_head   = head_ptr == '0 || head_ptr[1:0] != 2'b00;
        len_zero   = desc.len[LEN_W-1:0] == '0;
        fetch_done = ack && !rd_err && idx == 2'd3;
        done_evt   = (state == S_WAIT && xfer_done) || (fetch_done && len_zero);
        irq_evt    = state == S_WAIT ? xfer_done && desc.flags[F_IRQ] : fetch_done && len_zero && rd_data[F_IRQ];
        chain_end  = state == S_ADVANCE && (desc.flags[F_LAST] || desc.next == '0 || stop_pending || stop);
        next_bad   = desc.next[1:0] != 2'b00;
        case (state)
            S_IDLE, S_ERROR: state_n = accept ? (bad_head ? S_ERROR : S_FETCH) : state;
            S_FETCH:         state_n = ack && rd_err ? S_ERROR : fetch_done ? (len_zero ? S_ADVANCE : S_ISSUE) : S_FETCH;
            S_ISSUE:         state_n = cmd_ready ? S_WAIT : S_ISSUE;
            S_WAIT:          state_n = xfer_done ? S_ADVANCE : S_WAIT;
            S_ADVANCE:       state_n = chain_end ? S_IDLE : next_bad ? S_ERROR : S_FETCH;
            default:         state_n = S_IDLE;
        endcase
    end

    // state, status flags, completion counter and interrupt pulses
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state        <= S_IDLE;
            stop_pending <= 1'b0;
            err          <= 1'b0;
            desc_count   <= '0;
            irq_desc     <= 1'b0;
            irq_chain    <= 1'b0;
        end else begin
            state        <= state_n;
            stop_pending <= is_busy(state_n) && (stop_pending || (stop && busy));
            irq_desc     <= irq_evt;
            irq_chain    <= chain_end;
            err          <= accept ? bad_head : err || (ack && rd_err) || (state == S_ADVANCE && !chain_end && next_bad);
            desc_count   <= accept ? '0 : desc_count + CNT_W'(done_evt);
        end
    end

    // descriptor fetch: word index, one idle cycle after each ack, and the latched descriptor words
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cur_ptr <= '0;
            idx     <= '0;
            gap     <= 1'b0;
            words   <= '{default: '0};
        end else begin
            gap <= ack;
            if (accept) begin
                cur_ptr <= head_ptr;
                idx     <= '0;
            end
            if (ack) begin
                words[idx] <= rd_data;
                idx        <= idx + 2'd1;
            end
            if (state == S_ADVANCE && !chain_end && !next_bad)
                cur_ptr <= desc.next[ADDR_W-1:0];
        end
    end

endmodule
